btb_lookup: RTL and testbench
=============================

# btb_lookup

Branch target buffer on the fetch side of the out-of-order core. Accepts target writes from the branch functional unit and answers fetch lookups with a registered prediction `bp` / `bp_addr`. Fetch copies those two values into `decode_info.bp` / `decode_info.bp_addr` for each instruction. The branch unit later checks the prediction against the resolved outcome, so this block never corrects mispredictions itself.

## Interface
Parameters:
- `INDEX_BITS`, 8: index width. Number of entries is 2^INDEX_BITS; the index is `pc[INDEX_BITS+1:2]`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `btb_web`  in  1  write enable, active-low, from the branch unit
- `btb_addr`  in  INDEX_BITS  write index (the branch's `pc[9:2]` for the default width)
- `btb_din`  in  32  resolved taken target
- `lookup_req`  in  1  fetch lookup request
- `lookup_pc`  in  32  PC being fetched
- `lookup_stall`  in  1  fetch back-pressure; holds the current response
- `flush`  in  1  redirect; kills any in-flight or held response
- `resp_valid`  out  1  response valid
- `resp_pc`  out  32  PC the response belongs to
- `bp`  out  1  predicted taken (entry valid)
- `bp_addr`  out  32  predicted target; `32'h0` when `bp=0`

## Operation
- Storage:
  - `valid[2^INDEX_BITS]` flops, cleared by `rst`.
  - `target[2^INDEX_BITS]` words, not reset.
  - No tags. Aliasing between PCs that share an index is accepted; the branch unit catches the resulting wrong target.
- Write: at a posedge with `btb_web==0` and `rst==0`:
  - `target[btb_addr] <= btb_din`
  - `valid[btb_addr] <= 1`
  - No invalidate path exists. Only `rst` clears valid bits.
- Lookup accept: `lookup_req && !lookup_stall && !flush`.
- Response registers: `resp_valid`, `resp_pc`, `bp`, `bp_addr`. Update priority:
  1. `rst`: all response registers to 0.
  2. `flush`: `resp_valid <= 0`, `bp <= 0`, `bp_addr <= 0`. `resp_pc` is don't-care.
  3. `lookup_stall`: hold all response registers. Writes still commit to storage, but the held response is not re-read.
  4. Lookup accepted: `resp_valid <= 1`, `resp_pc <= lookup_pc`. `bp` / `bp_addr` come from entry `idx = lookup_pc[INDEX_BITS+1:2]`.
  5. Otherwise: `resp_valid <= 0`, `bp <= 0`, `bp_addr <= 0`.
- Write-first bypass: if a lookup is accepted in the same cycle as a write with `btb_addr == idx`, the response returns `bp=1` and `bp_addr=btb_din`.
- Entry value: `bp = valid[idx]`; `bp_addr = valid[idx] ? target[idx] : 0`. Stored targets are returned unmodified (no alignment masking).

## Timing
- Lookup latency: 1 cycle. A request accepted at edge N produces a response visible after edge N, through registered outputs.
- Throughput: 1 lookup per cycle when not stalled.
- Write-to-lookup visibility:
  - A write at edge N is visible to a lookup accepted at edge N, through the bypass.
  - It is also visible to any lookup accepted later.
- Reset values: every output is 0.
- `rst` asserted mid-operation:
  - Clears all valid bits and any held response in one cycle.
  - A write in the same cycle is dropped.
- `flush` and `lookup_req` in the same cycle: the request is dropped and `resp_valid=0` next cycle.
- `flush` and `lookup_stall` in the same cycle: flush wins.
- `flush` does not block a write in the same cycle; the write commits.
- Rewrite of a valid entry overwrites its target; the last write wins.

## Structure
- Shared package `rv32i_types`:
  - constant `BTB_INDEX_BITS = 8`
  - struct `btb_resp_t` {`valid`, `pc`, `bp`, `bp_addr`}
- One natural sub-module, `btb_array`:
  - contents: valid flops, target storage, write port, and write-first bypass
  - read: a combinational read of one index
- The response registers and priority logic stay in the top module.

## Test plan
- Reset, then lookup `pc=0x1000` → next cycle `resp_valid=1`, `resp_pc=0x1000`, `bp=0`, `bp_addr=0`.
- Write `addr=0x04`, `din=0x2000`; next cycle lookup `pc=0x0010` → `bp=1`, `bp_addr=0x2000`. Lookup `pc=0x0410` (same index, aliased) → `bp=1`, `bp_addr=0x2000`.
- Same-cycle write `addr=0x08`, `din=0x3000` and lookup `pc=0x0020` → response `bp=1`, `bp_addr=0x3000`.
- Lookup `pc=0x0010`, then hold `lookup_stall=1` for 3 cycles while writing `addr=0x04`, `din=0x5000` → the held response stays `bp_addr=0x2000`. After release, a new lookup of `0x0010` returns `0x5000`.
- `flush=1` together with `lookup_req` for `pc=0x0010` → next cycle `resp_valid=0`, `bp=0`. `flush` during a stalled valid response → `resp_valid` drops the next cycle.
- Fill 256 entries, assert `rst` for one cycle with `btb_web=0` → all lookups return `bp=0`, and the write made during reset is not present.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared fetch-side types: BTB geometry and the registered lookup response payload.
package rv32i_types;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned BTB_INDEX_BITS = 8;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            bp;
        logic [XLEN-1:0] bp_addr;
    } btb_resp_t;

endpackage

// File: rtl/btb_array.sv
// Untagged BTB storage: valid flops, target words, one write port and a
// write-first combinational read of a single index.
module btb_array
    import rv32i_types::*;
#(
    parameter int unsigned INDEX_BITS = BTB_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  web,
    input  logic [INDEX_BITS-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [INDEX_BITS-1:0] raddr,
    output logic                  rd_valid_c,
    output logic [XLEN-1:0]       rd_target_c
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];

    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (!web) begin
            valid_d[waddr]  = 1'b1;
            target_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Targets carry no reset; a write coinciding with reset is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            target_q <= target_d;
        end
    end

    always_comb begin
        rd_valid_c  = valid_q[raddr];
        rd_target_c = target_q[raddr];
        if (!web && (waddr == raddr)) begin
            rd_valid_c  = 1'b1;
            rd_target_c = wdata;
        end
    end

endmodule

// File: rtl/btb_lookup.sv
// Fetch-side branch target buffer: one-cycle registered prediction per accepted
// lookup, with stall hold and flush kill of the response.
module btb_lookup
    import rv32i_types::*;
#(
    parameter int unsigned INDEX_BITS = BTB_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btb_web,
    input  logic [INDEX_BITS-1:0] btb_addr,
    input  logic [31:0]           btb_din,
    input  logic                  lookup_req,
    input  logic [31:0]           lookup_pc,
    input  logic                  lookup_stall,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [31:0]           resp_pc,
    output logic                  bp,
    output logic [31:0]           bp_addr
);

    logic [INDEX_BITS-1:0] lookup_idx;
    logic                  rd_valid;
    logic [XLEN-1:0]       rd_target;
    btb_resp_t             resp_q;
    btb_resp_t             resp_d;

    assign lookup_idx = lookup_pc[INDEX_BITS+1:2];

    btb_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .web         (btb_web),
        .waddr       (btb_addr),
        .wdata       (btb_din),
        .raddr       (lookup_idx),
        .rd_valid_c  (rd_valid),
        .rd_target_c (rd_target)
    );

    // Flush beats stall; stall holds; otherwise sample a fresh lookup or go idle.
    always_comb begin
        resp_d = resp_q;
        if (flush) begin
            resp_d.valid   = 1'b0;
            resp_d.bp      = 1'b0;
            resp_d.bp_addr = '0;
        end else if (lookup_stall) begin
            resp_d = resp_q;
        end else if (lookup_req) begin
            resp_d.valid   = 1'b1;
            resp_d.pc      = lookup_pc;
            resp_d.bp      = rd_valid;
            resp_d.bp_addr = rd_valid ? rd_target : '0;
        end else begin
            resp_d.valid   = 1'b0;
            resp_d.bp      = 1'b0;
            resp_d.bp_addr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign resp_valid = resp_q.valid;
    assign resp_pc    = resp_q.pc;
    assign bp         = resp_q.bp;
    assign bp_addr    = resp_q.bp_addr;

endmodule

// File: tb/tb_btb_lookup.sv
// Directed, table-driven bench for btb_lookup with hand-computed expectations.
module tb_btb_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        btb_web;
    logic [7:0]  btb_addr;
    logic [31:0] btb_din;
    logic        lookup_req;
    logic [31:0] lookup_pc;
    logic        lookup_stall;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic        bp;
    logic [31:0] bp_addr;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    btb_lookup #(.INDEX_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .btb_web      (btb_web),
        .btb_addr     (btb_addr),
        .btb_din      (btb_din),
        .lookup_req   (lookup_req),
        .lookup_pc    (lookup_pc),
        .lookup_stall (lookup_stall),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_pc      (resp_pc),
        .bp           (bp),
        .bp_addr      (bp_addr)
    );

    typedef struct {
        logic        rst;
        logic        web;
        logic [7:0]  waddr;
        logic [31:0] din;
        logic        req;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        e_valid;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic        e_bp;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic [7:0] wa, logic [31:0] d,
                                logic rq, logic [31:0] p, logic st, logic fl,
                                logic ev, logic cp, logic [31:0] ep, logic eb,
                                logic [31:0] ea);
        vec_t v;
        v.rst = r; v.web = w; v.waddr = wa; v.din = d;
        v.req = rq; v.pc = p; v.stall = st; v.flush = fl;
        v.e_valid = ev; v.chk_pc = cp; v.e_pc = ep; v.e_bp = eb; v.e_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] wa, input logic [31:0] d,
                         input logic rq, input logic [31:0] p, input logic st, input logic fl);
        rst = r; btb_web = w; btb_addr = wa; btb_din = d;
        lookup_req = rq; lookup_pc = p; lookup_stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // rst web waddr din req pc stall flush | valid chkpc pc bp addr
        vecs.push_back(mk(1,1,8'h00,32'h0,   0,32'h0,   0,0, 0,1,32'h0,   0,32'h0));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h1000,0,0, 1,1,32'h1000,0,32'h0));
        vecs.push_back(mk(0,0,8'h04,32'h2000,0,32'h0,   0,0, 0,0,32'h0,   0,32'h0));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0010,0,0, 1,1,32'h0010,1,32'h2000));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0410,0,0, 1,1,32'h0410,1,32'h2000));
        vecs.push_back(mk(0,0,8'h08,32'h3000,1,32'h0020,0,0, 1,1,32'h0020,1,32'h3000));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0010,0,0, 1,1,32'h0010,1,32'h2000));
        vecs.push_back(mk(0,0,8'h04,32'h5000,1,32'h0044,1,0, 1,1,32'h0010,1,32'h2000));
        vecs.push_back(mk(0,0,8'h04,32'h5000,1,32'h0044,1,0, 1,1,32'h0010,1,32'h2000));
        vecs.push_back(mk(0,0,8'h04,32'h5000,1,32'h0010,1,0, 1,1,32'h0010,1,32'h2000));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0010,0,0, 1,1,32'h0010,1,32'h5000));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0010,0,1, 0,0,32'h0,   0,32'h0));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0020,0,0, 1,1,32'h0020,1,32'h3000));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0030,1,0, 1,1,32'h0020,1,32'h3000));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0030,1,1, 0,0,32'h0,   0,32'h0));
        vecs.push_back(mk(0,0,8'h0c,32'h7000,1,32'h0030,0,1, 0,0,32'h0,   0,32'h0));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0030,0,0, 1,1,32'h0030,1,32'h7000));
        vecs.push_back(mk(0,0,8'h0c,32'h7004,1,32'h0030,0,0, 1,1,32'h0030,1,32'h7004));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0030,0,0, 1,1,32'h0030,1,32'h7004));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0013,0,0, 1,1,32'h0013,1,32'h5000));
        vecs.push_back(mk(0,1,8'h00,32'h0,   1,32'h0050,0,0, 1,1,32'h0050,0,32'h0));
        vecs.push_back(mk(0,1,8'h00,32'h0,   0,32'h0010,0,0, 0,0,32'h0,   0,32'h0));

        foreach (vecs[i]) begin
            vec_t v;
            string tag;
            v = vecs[i];
            drive(v.rst, v.web, v.waddr, v.din, v.req, v.pc, v.stall, v.flush);
            tag = $sformatf("vec%0d", i);
            check({tag, ".resp_valid"}, 32'(resp_valid), 32'(v.e_valid));
            if (v.chk_pc) check({tag, ".resp_pc"}, resp_pc, v.e_pc);
            check({tag, ".bp"}, 32'(bp), 32'(v.e_bp));
            check({tag, ".bp_addr"}, bp_addr, v.e_addr);
        end

        // Fill all entries with unaligned targets to confirm no masking.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b0, 8'(i), 32'h8000_0003 | (32'(i) << 4), 1'b0, 32'h0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 256; i += 51) begin
            drive(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'(i) << 2, 1'b0, 1'b0);
            check($sformatf("fill%0d.bp", i), 32'(bp), 32'h1);
            check($sformatf("fill%0d.bp_addr", i), bp_addr, 32'h8000_0003 | (32'(i) << 4));
        end

        // Valid response held by stall, then reset with a concurrent write and lookup.
        drive(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'h0000_0154, 1'b0, 1'b0);
        check("prerst.bp_addr", bp_addr, 32'h8000_0553);
        drive(1'b1, 1'b0, 8'h55, 32'hdead_beef, 1'b1, 32'h0000_0154, 1'b1, 1'b0);
        check("rst.resp_valid", 32'(resp_valid), 32'h0);
        check("rst.resp_pc", resp_pc, 32'h0);
        check("rst.bp", 32'(bp), 32'h0);
        check("rst.bp_addr", bp_addr, 32'h0);

        begin
            int stale = 0;
            for (int i = 0; i < 256; i++) begin
                drive(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'(i) << 2, 1'b0, 1'b0);
                if (bp !== 1'b0 || bp_addr !== 32'h0 || resp_valid !== 1'b1) stale++;
            end
            check("postrst.stale_entries", 32'(stale), 32'h0);
        end
        drive(1'b0, 1'b1, 8'h00, 32'h0, 1'b1, 32'h0000_0154, 1'b0, 1'b0);
        check("postrst.idx55.bp", 32'(bp), 32'h0);
        check("postrst.idx55.bp_addr", bp_addr, 32'h0);

        idle();
        check("idle.resp_valid", 32'(resp_valid), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
